keypad_scan_debounce: RTL

- Upstream stage of the keypad-to-digit path.
- Drives the 4x4 matrix columns one at a time (active-low) and samples the rows.
- Debounces each press and presents the held key as a 16-bit one-hot code, which the downstream one-hot-to-binary encoder registers on every clk edge.
- One key is serviced at a time; multi-row presses are rejected.

---
 rtl/keypad_scan_debounce.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : keypad_scan_debounce                                       |
// | Description : 4x4 matrix keypad column scanner with press/release        |
// |               debounce, producing a sticky one-hot key code.             |
// |               Optional auto-repeat when KEY_REPEAT_EN is defined.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module keypad_scan_debounce #(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 20000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] onehot,
    output logic        key_valid,
    output logic        key_down
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CNT - 1);

    localparam logic [1:0] c_SCAN     = 2'd0;
    localparam logic [1:0] c_PRESS_DB = 2'd1;
    localparam logic [1:0] c_HOLD     = 2'd2;
    localparam logic [1:0] c_REL_DB   = 2'd3;

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("keypad_scan_debounce: parameter out of range");
    end

    logic [3:0]         sync1_q;
    logic [3:0]         rs_q;
    logic [1:0]         state_q,     state_d;
    logic [1:0]         col_idx_q,   col_idx_d;
    logic [1:0]         row_idx_q,   row_idx_d;
    logic [c_DIV_W-1:0] div_q,       div_d;
    logic [c_CNT_W-1:0] cnt_q,       cnt_d;
    logic [15:0]        onehot_q,    onehot_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q,  key_down_d;

`ifdef KEY_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

    logic [c_REP_W-1:0] rep_q, rep_d;
    logic               first_q, first_d;
`endif

    logic       w_idle;
    logic       w_single;
    logic [1:0] w_single_idx;
    logic       w_match;

    // Exactly one row low identifies a single key in the driven column.
    always_comb begin
        w_single     = 1'b1;
        w_single_idx = 2'd0;
        case (rs_q)
            4'b1110: w_single_idx = 2'd0;
            4'b1101: w_single_idx = 2'd1;
            4'b1011: w_single_idx = 2'd2;
            4'b0111: w_single_idx = 2'd3;
            default: w_single     = 1'b0;
        endcase
    end

    assign w_idle  = (rs_q == 4'b1111);
    assign w_match = (rs_q == ~(4'b0001 << row_idx_q));

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        onehot_d    = onehot_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
`ifdef KEY_REPEAT_EN
        rep_d       = '0;
        first_d     = 1'b1;
`endif
        case (state_q)
            c_SCAN: begin
                if (div_q == c_DIV_LAST) begin
                    div_d = '0;
                    if (w_single) begin
                        row_idx_d = w_single_idx;
                        cnt_d     = '0;
                        state_d   = c_PRESS_DB;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            c_PRESS_DB: begin
                if (!w_match) begin
                    state_d   = c_SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    div_d     = '0;
                    cnt_d     = '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = c_HOLD;
                    onehot_d    = 16'h0001 << {col_idx_q, row_idx_q};
                    key_valid_d = 1'b1;
                    key_down_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_HOLD: begin
                // A different non-idle pattern is ignored: the held key owns the scan.
                if (w_idle) begin
                    state_d = c_REL_DB;
                    cnt_d   = '0;
                end
`ifdef KEY_REPEAT_EN
                else begin
                    first_d = first_q;
                    if (rep_q == (first_q ? c_DELAY_LAST : c_PERIOD_LAST)) begin
                        key_valid_d = 1'b1;
                        rep_d       = '0;
                        first_d     = 1'b0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
                if (!w_idle) begin
                    state_d = c_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d    = c_SCAN;
                    key_down_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                    div_d      = '0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 4'b1111;
            rs_q        <= 4'b1111;
            state_q     <= c_SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            div_q       <= '0;
            cnt_q       <= '0;
            onehot_q    <= 16'h0000;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            sync1_q     <= row;
            rs_q        <= sync1_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            onehot_q    <= onehot_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q   <= '0;
            first_q <= 1'b1;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end
`endif

    assign col       = ~(4'b0001 << col_idx_q);
    assign onehot    = onehot_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
`default_nettype wire
